// File: rtl/seq_restoring_divider_pkg.sv
// Shared defaults and FSM encodings for the sequential restoring divider.
package seq_restoring_divider_pkg;
    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned VW_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned VW = 8
) (
    input  logic [VW-1:0] prem,
    input  logic          next_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] prem_nxt,
    output logic          q_bit
);
    logic [VW:0] t;
    logic [VW:0] diff;

    always_comb begin
        t     = {prem, next_bit};
        diff  = t - {1'b0, divisor};
        q_bit = (t >= {1'b0, divisor});
        // Either branch is < divisor, so the low VW bits hold it exactly.
        prem_nxt = q_bit ? diff[VW-1:0] : t[VW-1:0];
    end
endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned divider, one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned VW = VW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);
    localparam int unsigned CNT_W = (DW > 1) ? $clog2(DW) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    q;
    logic [VW-1:0]    prem;
    logic [VW-1:0]    dvs;
    logic [VW-1:0]    prem_nxt;
    logic             q_bit;

    div_step #(.VW(VW)) u_step (
        .prem     (prem),
        .next_bit (q[DW-1]),
        .divisor  (dvs),
        .prem_nxt (prem_nxt),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            q         <= '0;
            prem      <= '0;
            dvs       <= '0;
            div_zero  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        dvs <= divisor;
                        cnt <= '0;
                        if (divisor == '0) begin
                            q         <= '1;
                            prem      <= dividend[VW-1:0];
                            div_zero  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            q        <= dividend;
                            prem     <= '0;
                            div_zero <= 1'b0;
                            state    <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    prem <= prem_nxt;
                    q    <= {q[DW-2:0], q_bit};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(DW-1)) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign quotient  = q;
    assign remainder = prem;
endmodule
